interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer_pkg.sv | 36 +++
 rtl/interrupt_sequencer_drain_counter.sv | 38 +++
 rtl/interrupt_sequencer.sv | 155 +++++++++++++++
 tb/tb_interrupt_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared fetch-side definitions: interrupt sequencer state encoding and the
// micro-op kinds it injects, so decode can interpret the same codes.
package interrupt_sequencer_pkg;

    // Sequencer states; IDLE must stay encoded as zero (reset value)
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CAPTURE    = 3'd1,
        ST_PUSH_HI    = 3'd2,
        ST_PUSH_LO    = 3'd3,
        ST_PUSH_FLAGS = 3'd4,
        ST_JUMP       = 3'd5,
        ST_DRAIN      = 3'd6
    } seq_state_e;

    // Injected micro-op kinds as seen by decode
    typedef enum logic [1:0] {
        KIND_PUSH_PC_HI  = 2'd0,
        KIND_PUSH_PC_LO  = 2'd1,
        KIND_PUSH_FLAGS  = 2'd2,
        KIND_JUMP_VECTOR = 2'd3
    } uop_kind_e;

    // Bits needed to hold max_val, never less than one
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((max_val >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_drain_counter.sv
// Down-counter used to time the quiet period after the jump micro-op.
// Load has priority over decrement; the count saturates at zero.
module drain_counter #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load, else decrement while non-zero, else hold
    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == '0);

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: on an interrupt request it freezes fetch,
// captures the next PC and injects PUSH_PC_HI, PUSH_PC_LO, PUSH_FLAGS and
// JUMP_VECTOR micro-ops into decode, then drains before accepting another.
// All outputs are decoded from registered state only.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_interrupt_call,
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_stall,
    output logic            o_fetch_hold,
    output logic            o_inject_valid,
    output logic [1:0]      o_inject_kind,
    output logic [PC_W-1:0] o_inject_data,
    output logic            o_hold_enable,
    output logic            o_busy
);

    localparam int HALF_W     = PC_W / 2;
    // The counter is loaded on the JUMP hand-off; DRAIN lasts load+1 cycles
    localparam int DRAIN_LOAD = (DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0;
    localparam int CNT_W      = cnt_width(DRAIN_LOAD);

    seq_state_e      state_q;
    seq_state_e      state_d;
    logic [PC_W-1:0] saved_pc_q;
    logic [PC_W-1:0] saved_pc_d;
    logic            pending_q;
    logic            pending_d;

    logic            drain_load;
    logic            drain_dec;
    logic            drain_zero;

    logic [PC_W-1:0] pc_hi_ext;
    logic [PC_W-1:0] pc_lo_ext;

    assign pc_hi_ext = {{HALF_W{1'b0}}, saved_pc_q[PC_W-1:HALF_W]};
    assign pc_lo_ext = {{(PC_W-HALF_W){1'b0}}, saved_pc_q[HALF_W-1:0]};

    drain_counter #(
        .W (CNT_W)
    ) u_drain_counter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (drain_load),
        .i_load_val (CNT_W'(DRAIN_LOAD)),
        .i_dec      (drain_dec),
        .o_zero     (drain_zero)
    );

    // State, captured PC and pending-request registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            saved_pc_q <= '0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            saved_pc_q <= saved_pc_d;
            pending_q  <= pending_d;
        end
    end

    // Next-state logic plus state-decoded outputs
    always_comb begin
        state_d        = state_q;
        saved_pc_d     = saved_pc_q;
        pending_d      = pending_q;
        drain_load     = 1'b0;
        drain_dec      = 1'b0;
        o_fetch_hold   = 1'b0;
        o_inject_valid = 1'b0;
        o_inject_kind  = KIND_PUSH_PC_HI;
        o_inject_data  = '0;

        // A request arriving while busy is remembered once; extras are lost
        if ((state_q != ST_IDLE) && i_interrupt_call) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_interrupt_call || pending_q) begin
                    state_d   = ST_CAPTURE;
                    pending_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                o_fetch_hold = 1'b1;
                saved_pc_d   = i_pc;
                state_d      = ST_PUSH_HI;
            end
            ST_PUSH_HI: begin
                o_fetch_hold   = 1'b1;
                o_inject_valid = 1'b1;
                o_inject_kind  = KIND_PUSH_PC_HI;
                o_inject_data  = pc_hi_ext;
                if (!i_stall) begin
                    state_d = ST_PUSH_LO;
                end
            end
            ST_PUSH_LO: begin
                o_fetch_hold   = 1'b1;
                o_inject_valid = 1'b1;
                o_inject_kind  = KIND_PUSH_PC_LO;
                o_inject_data  = pc_lo_ext;
                if (!i_stall) begin
                    state_d = ST_PUSH_FLAGS;
                end
            end
            ST_PUSH_FLAGS: begin
                o_fetch_hold   = 1'b1;
                o_inject_valid = 1'b1;
                o_inject_kind  = KIND_PUSH_FLAGS;
                if (!i_stall) begin
                    state_d = ST_JUMP;
                end
            end
            ST_JUMP: begin
                o_fetch_hold   = 1'b1;
                o_inject_valid = 1'b1;
                o_inject_kind  = KIND_JUMP_VECTOR;
                if (!i_stall) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_DRAIN;
                        drain_load = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Fetch resumes here; stall has no effect on the drain timer
                if (drain_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_hold_enable = ~o_busy;

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

    localparam int PC_W = 32;
    localparam int D    = 3;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_interrupt_call;
    logic [PC_W-1:0] i_pc;
    logic            i_stall;
    logic            o_fetch_hold;
    logic            o_inject_valid;
    logic [1:0]      o_inject_kind;
    logic [PC_W-1:0] o_inject_data;
    logic            o_hold_enable;
    logic            o_busy;

    interrupt_sequencer #(
        .PC_W         (PC_W),
        .DRAIN_CYCLES (D)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_interrupt_call (i_interrupt_call),
        .i_pc             (i_pc),
        .i_stall          (i_stall),
        .o_fetch_hold     (o_fetch_hold),
        .o_inject_valid   (o_inject_valid),
        .o_inject_kind    (o_inject_kind),
        .o_inject_data    (o_inject_data),
        .o_hold_enable    (o_hold_enable),
        .o_busy           (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks;
    int passes;

    // Reference model: position within the interrupt entry sequence.
    // 0 idle, 1 capture, 2..5 the four micro-ops, 6..5+D drain cycles.
    int              m_step;
    bit              m_pend;
    logic [PC_W-1:0] m_saved;

    // Observation log
    int              cyc;
    int              hi_cycles[$];
    int              jump_count;
    logic [PC_W-1:0] last_lo_data;

    typedef struct {
        logic            call;
        logic [PC_W-1:0] pc;
        logic            stall;
        logic            exp_valid;
        logic [1:0]      exp_kind;
        logic [PC_W-1:0] exp_data;
        logic            exp_hold;
        logic            exp_busy;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic c, logic [PC_W-1:0] p, logic s, logic v,
                                logic [1:0] k, logic [PC_W-1:0] d, logic h, logic b);
        vec_t r;
        r.call = c; r.pc = p; r.stall = s;
        r.exp_valid = v; r.exp_kind = k; r.exp_data = d;
        r.exp_hold = h; r.exp_busy = b;
        return r;
    endfunction

    task automatic compare(string name, logic [37:0] act, logic [37:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s cycle %0d: got v/k/data/hold/busy/hen=%h required %h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic logic [37:0] pack_dut(logic mask_valid);
        logic [1:0]      k;
        logic [PC_W-1:0] d;
        k = mask_valid ? o_inject_kind : 2'd0;
        d = mask_valid ? o_inject_data : '0;
        return {o_inject_valid, k, d, o_fetch_hold, o_busy, o_hold_enable};
    endfunction

    task automatic check_model(string name);
        logic            ev;
        logic [1:0]      ek;
        logic [PC_W-1:0] ed;
        logic            eh;
        logic            eb;
        ev = (m_step >= 2) && (m_step <= 5);
        ek = ev ? 2'(m_step - 2) : 2'd0;
        ed = '0;
        if (ev && ek == 2'd0) ed = m_saved >> (PC_W / 2);
        if (ev && ek == 2'd1) ed = m_saved & 32'h0000_FFFF;
        eh = (m_step >= 1) && (m_step <= 5);
        eb = (m_step != 0);
        compare(name, pack_dut(ev), {ev, ek, ed, eh, eb, ~eb});
    endtask

    task automatic check_reset_outputs(string name);
        compare(name, {o_inject_valid, o_inject_kind, o_inject_data, o_fetch_hold, o_busy, o_hold_enable},
                {1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic model_update(logic call, logic [PC_W-1:0] pc, logic stall);
        if (m_step == 0) begin
            if (call || m_pend) begin
                m_step = 1;
                m_pend = 0;
            end
        end else begin
            if (call) m_pend = 1;
            if (m_step == 1) begin
                m_saved = pc;
                m_step  = 2;
            end else if (m_step <= 5) begin
                if (!stall) begin
                    m_step++;
                    if (m_step == 6 && D == 0) m_step = 0;
                end
            end else begin
                m_step++;
                if (m_step == 6 + D) m_step = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_step  = 0;
        m_pend  = 0;
        m_saved = '0;
    endtask

    task automatic observe();
        if (o_inject_valid && o_inject_kind == 2'd0) hi_cycles.push_back(cyc);
        if (o_inject_valid && o_inject_kind == 2'd3) jump_count++;
        if (o_inject_valid && o_inject_kind == 2'd1) last_lo_data = o_inject_data;
    endtask

    // One clock cycle: apply inputs, check against the model, advance
    task automatic drive(string name, logic call, logic [PC_W-1:0] pc, logic stall);
        i_interrupt_call = call;
        i_pc             = pc;
        i_stall          = stall;
        #1;
        observe();
        check_model(name);
        model_update(call, pc, stall);
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [PC_W-1:0] pc_a;
        logic [PC_W-1:0] pc_b;
        checks = 0; passes = 0; cyc = 0; jump_count = 0; last_lo_data = '0;
        pc_a = 32'h0000_1234;
        pc_b = 32'hABCD_5678;
        model_reset();

        // Directed table: plain sequence, then a sequence with a 4-cycle stall in PUSH_LO
        vecs[0]  = mk(1, pc_a, 0, 0, 0, 0,    0, 0);
        vecs[1]  = mk(0, pc_a, 0, 0, 0, 0,    1, 1);
        vecs[2]  = mk(0, pc_a, 0, 1, 0, 0,    1, 1);
        vecs[3]  = mk(0, pc_a, 0, 1, 1, pc_a, 1, 1);
        vecs[4]  = mk(0, pc_a, 0, 1, 2, 0,    1, 1);
        vecs[5]  = mk(0, pc_a, 0, 1, 3, 0,    1, 1);
        vecs[6]  = mk(0, pc_a, 0, 0, 0, 0,    0, 1);
        vecs[7]  = mk(0, pc_a, 1, 0, 0, 0,    0, 1);
        vecs[8]  = mk(0, pc_a, 0, 0, 0, 0,    0, 1);
        vecs[9]  = mk(0, pc_a, 0, 0, 0, 0,    0, 0);
        vecs[10] = mk(1, pc_a, 0, 0, 0, 0,    0, 0);
        vecs[11] = mk(0, pc_a, 0, 0, 0, 0,    1, 1);
        vecs[12] = mk(0, pc_a, 0, 1, 0, 0,    1, 1);
        vecs[13] = mk(0, pc_a, 1, 1, 1, pc_a, 1, 1);
        vecs[14] = mk(0, pc_a, 1, 1, 1, pc_a, 1, 1);
        vecs[15] = mk(0, pc_a, 1, 1, 1, pc_a, 1, 1);
        vecs[16] = mk(0, pc_a, 1, 1, 1, pc_a, 1, 1);
        vecs[17] = mk(0, pc_a, 0, 1, 1, pc_a, 1, 1);
        vecs[18] = mk(0, pc_a, 0, 1, 2, 0,    1, 1);
        vecs[19] = mk(0, pc_a, 0, 1, 3, 0,    1, 1);
        vecs[20] = mk(0, pc_a, 0, 0, 0, 0,    0, 1);
        vecs[21] = mk(0, pc_a, 0, 0, 0, 0,    0, 1);
        vecs[22] = mk(0, pc_a, 0, 0, 0, 0,    0, 1);
        vecs[23] = mk(0, pc_a, 0, 0, 0, 0,    0, 0);

        // Reset state
        i_rst_n = 1'b0; i_interrupt_call = 1'b0; i_pc = '0; i_stall = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        repeat (2) @(posedge i_clk);
        #1;
        check_reset_outputs("reset_held");
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Table-driven vectors
        for (int i = 0; i < 24; i++) begin
            i_interrupt_call = vecs[i].call;
            i_pc             = vecs[i].pc;
            i_stall          = vecs[i].stall;
            #1;
            compare($sformatf("table[%0d]", i), pack_dut(vecs[i].exp_valid),
                    {vecs[i].exp_valid, vecs[i].exp_kind, vecs[i].exp_data,
                     vecs[i].exp_hold, vecs[i].exp_busy, ~vecs[i].exp_busy});
            model_update(vecs[i].call, vecs[i].pc, vecs[i].stall);
            @(posedge i_clk);
            #1;
            cyc++;
        end

        // Second pulse during PUSH_HI: follow-up sequence captures the new PC
        hi_cycles.delete();
        drive("req2_pulse", 1, pc_a, 0);
        drive("req2_capture", 0, pc_a, 0);
        drive("req2_hi", 1, pc_b, 0);
        for (int i = 0; i < 16; i++) drive("req2_run", 0, pc_b, 0);
        compare("req2_hi_count", 38'(hi_cycles.size()), 38'd2);
        if (hi_cycles.size() == 2)
            compare("req2_restart_gap", 38'(hi_cycles[1] - hi_cycles[0]), 38'(6 + D));
        compare("req2_recaptured_lo", 38'(last_lo_data), 38'(pc_b & 32'h0000_FFFF));

        // Three pulses during one sequence: exactly one extra sequence
        hi_cycles.delete();
        drive("req3_pulse", 1, pc_a, 0);
        drive("req3_capture", 1, pc_a, 0);
        drive("req3_hi", 1, pc_a, 0);
        drive("req3_lo", 1, pc_a, 0);
        for (int i = 0; i < 30; i++) drive("req3_run", 0, pc_a, 0);
        compare("req3_hi_count", 38'(hi_cycles.size()), 38'd2);

        // Reset asserted during PUSH_FLAGS abandons the sequence
        drive("rst_pulse", 1, pc_a, 0);
        drive("rst_capture", 0, pc_a, 0);
        drive("rst_hi", 0, pc_a, 0);
        drive("rst_lo", 0, pc_a, 0);
        i_interrupt_call = 1'b0;
        i_stall = 1'b0;
        #2;
        compare("rst_in_flags_kind", 38'(o_inject_valid && o_inject_kind == 2'd2), 38'd1);
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_immediate");
        model_reset();
        @(posedge i_clk);
        #1;
        check_reset_outputs("rst_mid_held");
        i_rst_n = 1'b1;
        jump_count = 0;
        for (int i = 0; i < 10; i++) drive("rst_after", 0, pc_a, 0);
        compare("rst_no_jump", 38'(jump_count), 38'd0);

        // Randomized stimulus against the reference model
        for (int i = 0; i < 800; i++) begin
            drive("random", ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
